// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the data-ram arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    ARB,
    LOCK
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_DMA
  } owner_t;

endpackage

// File: rtl/arb_wait_ctr.sv
// Saturating wait counter: counts cycles the dma has been refused, reports when
// it has waited MAX cycles.
module arb_wait_ctr #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [W-1:0] cnt_q;

  assign sat = (cnt_q == W'(MAX));

  // Count refused cycles up to MAX; clear has priority over increment.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !sat) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the single-port data ram (1-cycle sync read).
// Port 0 = cpu (fixed priority), port 1 = dma (starvation guard + bus lock).
// Optional feature macro: ARB_PERF_CNT_EN adds grant/conflict counters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_wen,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_lock,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_wen,
  input  logic [DATA_W-1:0] ram_out
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       cpu_gnt_cnt,
  output logic [31:0]       dma_gnt_cnt,
  output logic [31:0]       conflict_cnt
`endif
);

  arb_state_t state_q;
  owner_t     owner_q;
  logic       wait_sat;
  logic       arb_mode;

  arb_wait_ctr #(.MAX(MAX_WAIT)) u_wait_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (dma_req && !dma_gnt),
    .clr   (dma_gnt || !dma_req),
    .sat   (wait_sat)
  );

  // Grant decision: normal arbitration in ARB or on the cycle the lock drops.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    cpu_gnt  = 1'b0;
    dma_gnt  = 1'b0;
    arb_mode = (state_q == ARB) || !dma_lock;
    if (arb_mode) begin
      dma_gnt = dma_req && (!cpu_req || wait_sat);
      cpu_gnt = cpu_req && !dma_gnt;
    end else begin
      dma_gnt = dma_req;
    end
  end

  // Ram mux from the granted port; writes are suppressed while in reset.
  always_comb begin
    ram_addr = cpu_addr;
    ram_in   = cpu_wdata;
    ram_wen  = 1'b0;
    if (dma_gnt) begin
      ram_addr = dma_addr;
      ram_in   = dma_wdata;
      ram_wen  = dma_wen;
    end else if (cpu_gnt) begin
      ram_wen  = cpu_wen;
    end
    if (!rst_n) begin
      ram_wen = 1'b0;
    end
  end

  // Lock state and read-owner tag for the data returning next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB;
      owner_q <= OWN_NONE;
    end else begin
      if (dma_gnt && dma_lock) begin
        state_q <= LOCK;
      end else if (!dma_lock) begin
        state_q <= ARB;
      end

      if (cpu_gnt && !cpu_wen) begin
        owner_q <= OWN_CPU;
      end else if (dma_gnt && !dma_wen) begin
        owner_q <= OWN_DMA;
      end else begin
        owner_q <= OWN_NONE;
      end
    end
  end

  // Read data is steered by the tag; a reset cycle kills any in-flight return.
  assign cpu_rvalid = rst_n && (owner_q == OWN_CPU);
  assign dma_rvalid = rst_n && (owner_q == OWN_DMA);
  assign cpu_rdata  = ram_out;
  assign dma_rdata  = ram_out;

`ifdef ARB_PERF_CNT_EN
  // Free-running wrapping counters of grants and contended cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpu_gnt_cnt  <= '0;
      dma_gnt_cnt  <= '0;
      conflict_cnt <= '0;
    end else begin
      if (cpu_gnt)            cpu_gnt_cnt  <= cpu_gnt_cnt + 32'd1;
      if (dma_gnt)            dma_gnt_cnt  <= dma_gnt_cnt + 32'd1;
      if (cpu_req && dma_req) conflict_cnt <= conflict_cnt + 32'd1;
    end
  end
`endif

endmodule
